board_input_conditioner: RTL and testbench
==========================================

// Module: board_input_conditioner
// PURPOSE
//  Board-level input conditioner that sits between the raw pins and the debug/application top.
//  Synchronises and debounces NUM_SW switches and NUM_BTN buttons, and emits one-cycle press and
//  release pulses per button. Generates a stretched system reset from three sources: the async pin
//  reset, a chosen debounced switch and the PLL lock.
// PARAMETERS
//  NUM_SW          4      number of slide switches
//  NUM_BTN         5      number of push buttons
//  SYNC_STAGES     2      synchroniser depth, >=2
//  DEBOUNCE_CYCLES 65536  cycles an input must differ from its stable value before the stable value updates, >=2
//  RESET_SW_INDEX  0      switch whose debounced low holds sys_reset_n low
//  RESET_STRETCH   1024   cycles sys_reset_n stays low after all reset conditions clear, >=1
//  LONG_CYCLES     2**24  long-press threshold in cycles; used only with BIC_LONG_PRESS_EN
// PORTS
//  clk            in   1        single clock; all logic is on its rising edge
//  reset_n        in   1        asynchronous, active-low reset
//  switches_raw   in   NUM_SW   raw switch pins (asynchronous)
//  buttons_raw    in   NUM_BTN  raw button pins (asynchronous, active high)
//  pll_locked     in   1        PLL lock (asynchronous)
//  switches       out  NUM_SW   debounced switch levels
//  buttons        out  NUM_BTN  debounced button levels
//  btn_pressed    out  NUM_BTN  1-cycle pulse when buttons[i] rises
//  btn_released   out  NUM_BTN  1-cycle pulse when buttons[i] falls
//  btn_long       out  NUM_BTN  1-cycle long-press pulse; tied to 0 without BIC_LONG_PRESS_EN
//  sys_reset_n    out  1        registered, stretched system reset, active low
// BEHAVIOUR
//  - Reset (reset_n=0, async): all flops go to 0. All outputs read 0, sys_reset_n included.
//  - Sync: each raw input, including pll_locked, passes through SYNC_STAGES flops to give s[i].
//  - Debounce, per input, with stable value st[i] and counter c[i] (width $clog2(DEBOUNCE_CYCLES)):
//    - s==st: c<=0.
//    - s!=st and c<DEBOUNCE_CYCLES-1: c<=c+1.
//    - s!=st and c==DEBOUNCE_CYCLES-1: st<=s, c<=0.
//    - Any glitch back to st restarts the count, so a bouncing input never updates.
//    - Latency: st changes exactly SYNC_STAGES+DEBOUNCE_CYCLES clock edges after the first edge
//      that samples a level held steady from then on.
//  - switches and buttons are st, registered.
//  - btn_pressed[i] is high for the one cycle after buttons[i] goes 0->1. btn_released[i] is the
//    same for 1->0.
//  - A button already held at reset release is seen as a 0->1 change, so it produces one press pulse.
//  - Simultaneous events on several inputs are handled independently and may pulse in the same cycle.
//  - Reset FSM, states HOLD and STRETCH, plus a RUN condition:
//    - A condition is active if switches[RESET_SW_INDEX]==0 or the synced pll_locked==0.
//    - HOLD: sys_reset_n=0, stretch counter=0. Go to STRETCH on the first cycle with no condition active.
//    - STRETCH: count up. Any active condition returns to HOLD on the next edge, counter cleared.
//    - When the counter reaches RESET_STRETCH-1, sys_reset_n<=1 (RUN).
//    - RUN: any active condition drives sys_reset_n<=0 on the next edge and re-enters HOLD.
//  - Pin reset_n forces HOLD and clears all counters immediately, including mid-debounce and mid-stretch.
// CONFIGURATION
//  BIC_LONG_PRESS_EN defined:
//    - Per-button hold counter, width $clog2(LONG_CYCLES+1), cleared while buttons[i]==0.
//    - btn_long[i] pulses once, exactly LONG_CYCLES cycles after buttons[i] rose.
//    - The counter then saturates: no repeat until the button is released and pressed again.
//  BIC_LONG_PRESS_EN undefined:
//    - No long-press counters are synthesised and btn_long is constant 0.
//    - All other behaviour is identical.
// TESTING
//  Params for all tests: SYNC_STAGES=2, DEBOUNCE_CYCLES=16, RESET_STRETCH=32, LONG_CYCLES=100.
//  1 Reset: reset_n=0 with all raw inputs at 1.
//    -> All outputs 0 throughout, sys_reset_n=0.
//  2 Bounce: buttons_raw[0] toggles every 5 cycles for 60 cycles, then holds 1.
//    -> No change before the final edge.
//    -> buttons[0]=1 exactly 18 edges after the final edge.
//    -> Exactly one btn_pressed[0] pulse, no btn_released.
//  3 Reset release: switches_raw[0]=1 and pll_locked=1 from reset release.
//    -> switches[0]=1 after 18 edges.
//    -> sys_reset_n rises 32 edges later.
//  4 Lock loss: in RUN, pll_locked=0 for 1 cycle.
//    -> sys_reset_n=0 within 3 edges.
//    -> Full 32-cycle stretch repeats after relock.
//  5 Simultaneous: buttons_raw[1] and [3] rise on the same edge and are held.
//    -> btn_pressed[1] and [3] pulse in the same cycle.
//    -> On release, btn_released[1] and [3] pulse in the same cycle.
//  6 Mid-operation reset: reset_n pulsed low mid-debounce and mid-stretch.
//    -> All outputs 0 at once; counts restart from 0.
//    -> With BIC_LONG_PRESS_EN, a held button gives exactly one btn_long pulse 100 cycles after
//       buttons rises; none without the macro.

Source files
------------

// File: rtl/board_input_conditioner.sv
// Synchronises and debounces board switches/buttons and builds a stretched system reset.
// Optional long-press detection is enabled by defining BIC_LONG_PRESS_EN.
module board_input_conditioner #(
    parameter int NUM_SW          = 4,
    parameter int NUM_BTN         = 5,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int RESET_SW_INDEX  = 0,
    parameter int RESET_STRETCH   = 1024,
    parameter int LONG_CYCLES     = 2**24
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SW-1:0]  switches_raw,
    input  logic [NUM_BTN-1:0] buttons_raw,
    input  logic               pll_locked,
    output logic [NUM_SW-1:0]  switches,
    output logic [NUM_BTN-1:0] buttons,
    output logic [NUM_BTN-1:0] btn_pressed,
    output logic [NUM_BTN-1:0] btn_released,
    output logic [NUM_BTN-1:0] btn_long,
    output logic               sys_reset_n
);

    localparam int NIN = NUM_SW + NUM_BTN;
    localparam int DW  = $clog2(DEBOUNCE_CYCLES);
    localparam int RW  = (RESET_STRETCH > 1) ? $clog2(RESET_STRETCH) : 1;

    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] RS_PRE  = RW'(RESET_STRETCH - 2);

    typedef enum logic [1:0] {
        HOLD,
        STRETCH,
        RUN
    } rst_state_t;

    logic [NIN:0]   sync_q [SYNC_STAGES];
    logic [NIN:0]   s_all;
    logic           pll_s;
    logic [NIN-1:0] st;
    logic [DW-1:0]  cnt [NIN];
    logic [NUM_BTN-1:0] btn_prev;

    rst_state_t state_q, state_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          sysrst_q, sysrst_d;
    logic          cond;

    // pll_locked rides in the top bit of the synchroniser bundle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= {pll_locked, buttons_raw, switches_raw};
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s_all = sync_q[SYNC_STAGES-1];
    assign pll_s = s_all[NIN];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st <= '0;
            for (int i = 0; i < NIN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NIN; i++) begin
                if (s_all[i] == st[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DB_LAST) begin
                    st[i]  <= s_all[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign switches = st[NUM_SW-1:0];
    assign buttons  = st[NIN-1:NUM_SW];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_prev <= '0;
        end else begin
            btn_prev <= buttons;
        end
    end

    assign btn_pressed  = buttons & ~btn_prev;
    assign btn_released = ~buttons & btn_prev;

    assign cond = ~switches[RESET_SW_INDEX] | ~pll_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= HOLD;
            rcnt_q   <= '0;
            sysrst_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rcnt_q   <= rcnt_d;
            sysrst_q <= sysrst_d;
        end
    end

    // Entering STRETCH counts as count 0, so release lands RESET_STRETCH edges after clear
    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        sysrst_d = sysrst_q;
        unique case (state_q)
            HOLD: begin
                rcnt_d   = '0;
                sysrst_d = 1'b0;
                if (!cond) begin
                    if (RESET_STRETCH == 1) begin
                        state_d  = RUN;
                        sysrst_d = 1'b1;
                    end else begin
                        state_d = STRETCH;
                    end
                end
            end
            STRETCH: begin
                if (cond) begin
                    state_d  = HOLD;
                    rcnt_d   = '0;
                    sysrst_d = 1'b0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
                    if (rcnt_q == RS_PRE) begin
                        state_d  = RUN;
                        sysrst_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cond) begin
                    state_d  = HOLD;
                    rcnt_d   = '0;
                    sysrst_d = 1'b0;
                end
            end
            default: begin
                state_d  = HOLD;
                rcnt_d   = '0;
                sysrst_d = 1'b0;
            end
        endcase
    end

    assign sys_reset_n = sysrst_q;

`ifdef BIC_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LONG_MAX = LW'(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_PRE = LW'(LONG_CYCLES - 1);

    logic [LW-1:0]      hcnt [NUM_BTN];
    logic [NUM_BTN-1:0] long_q;

    // Hold counter saturates at LONG_CYCLES so the pulse fires once per press
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            long_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) begin
                hcnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BTN; i++) begin
                long_q[i] <= buttons[i] && (hcnt[i] == LONG_PRE);
                if (!buttons[i]) begin
                    hcnt[i] <= '0;
                end else if (hcnt[i] != LONG_MAX) begin
                    hcnt[i] <= hcnt[i] + 1'b1;
                end
            end
        end
    end

    assign btn_long = long_q;
`else
    assign btn_long = '0;
`endif

endmodule

// File: tb/tb_board_input_conditioner.sv
// Scoreboard bench: stimulus queues expected output events, a negedge monitor pops and compares.
module tb_board_input_conditioner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] switches_raw;
    logic [4:0] buttons_raw;
    logic       pll_locked;
    logic [3:0] switches;
    logic [4:0] buttons;
    logic [4:0] btn_pressed;
    logic [4:0] btn_released;
    logic [4:0] btn_long;
    logic       sys_reset_n;

    board_input_conditioner #(
        .NUM_SW(4),
        .NUM_BTN(5),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(16),
        .RESET_SW_INDEX(0),
        .RESET_STRETCH(32),
        .LONG_CYCLES(100)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .switches_raw(switches_raw),
        .buttons_raw(buttons_raw),
        .pll_locked(pll_locked),
        .switches(switches),
        .buttons(buttons),
        .btn_pressed(btn_pressed),
        .btn_released(btn_released),
        .btn_long(btn_long),
        .sys_reset_n(sys_reset_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int kind;
        int idx;
        int val;
    } ev_t;

    ev_t expq[$];
    int  total = 0;
    int  bad = 0;
    string kn [6] = '{"switch", "button", "pressed", "released", "long", "sys_reset_n"};

    function automatic int key(ev_t e);
        return e.cyc * 64 + e.kind * 8 + e.idx;
    endfunction

    // Sorted insert lets tests queue events in any order
    task automatic expect_ev(int c, int k, int i, int v);
        ev_t e;
        int  pos;
        e.cyc = c;
        e.kind = k;
        e.idx = i;
        e.val = v;
        pos = expq.size();
        for (int j = 0; j < expq.size(); j++) begin
            if (key(expq[j]) > key(e)) begin
                pos = j;
                break;
            end
        end
        expq.insert(pos, e);
    endtask

    task automatic got(int k, int i, int v);
        ev_t e;
        total++;
        if (expq.size() == 0) begin
            bad++;
            $display("FAIL unexpected %s[%0d]=%0d at cycle %0d, none queued",
                     kn[k], i, v, cyc);
        end else begin
            e = expq.pop_front();
            if (e.cyc != cyc || e.kind != k || e.idx != i || e.val != v) begin
                bad++;
                $display("FAIL event got %s[%0d]=%0d at cycle %0d, want %s[%0d]=%0d at cycle %0d",
                         kn[k], i, v, cyc, kn[e.kind], e.idx, e.val, e.cyc);
            end
        end
    endtask

    task automatic chk_zero(string name);
        logic [24:0] all;
        all = {switches, buttons, btn_pressed, btn_released, btn_long, sys_reset_n};
        total++;
        if (all !== '0) begin
            bad++;
            $display("FAIL %s outputs=%h want 0", name, all);
        end
    endtask

    logic [3:0] p_sw = '0;
    logic [4:0] p_btn = '0;
    logic       p_sys = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++)
            if (switches[i] !== p_sw[i]) got(0, i, int'(switches[i]));
        for (int i = 0; i < 5; i++)
            if (buttons[i] !== p_btn[i]) got(1, i, int'(buttons[i]));
        for (int i = 0; i < 5; i++)
            if (btn_pressed[i] !== 1'b0) got(2, i, int'(btn_pressed[i]));
        for (int i = 0; i < 5; i++)
            if (btn_released[i] !== 1'b0) got(3, i, int'(btn_released[i]));
        for (int i = 0; i < 5; i++)
            if (btn_long[i] !== 1'b0) got(4, i, int'(btn_long[i]));
        if (sys_reset_n !== p_sys) got(5, 0, int'(sys_reset_n));
        p_sw = switches;
        p_btn = buttons;
        p_sys = sys_reset_n;
    end

    task automatic step(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int r, f, t4, t5, t6;

    initial begin
        reset_n = 1'b0;
        switches_raw = '1;
        buttons_raw = '1;
        pll_locked = 1'b1;
        step(3);
        chk_zero("reset_a");
        step(1);
        chk_zero("reset_b");
        step(1);
        chk_zero("reset_c");

        // Reset release: sw0, sw2 and held button 4 settle after 18 edges
        switches_raw = 4'b0101;
        buttons_raw = 5'b10000;
        step(1);
        r = cyc;
        reset_n = 1'b1;
        expect_ev(r + 18, 0, 0, 1);
        expect_ev(r + 18, 0, 2, 1);
        expect_ev(r + 18, 1, 4, 1);
        expect_ev(r + 18, 2, 4, 1);
        expect_ev(r + 50, 5, 0, 1);
`ifdef BIC_LONG_PRESS_EN
        expect_ev(r + 118, 4, 4, 1);
`endif
        step(60);

        // Bounce on button 0, then hold high
        for (int k = 0; k < 12; k++) begin
            buttons_raw[0] = (k % 2 == 0);
            step(5);
        end
        buttons_raw[0] = 1'b1;
        f = cyc;
        expect_ev(f + 18, 1, 0, 1);
        expect_ev(f + 18, 2, 0, 1);
`ifdef BIC_LONG_PRESS_EN
        expect_ev(f + 118, 4, 0, 1);
`endif
        step(30);

        // One-cycle lock loss while running
        t4 = cyc;
        pll_locked = 1'b0;
        expect_ev(t4 + 3, 5, 0, 0);
        expect_ev(t4 + 35, 5, 0, 1);
        step(1);
        pll_locked = 1'b1;
        step(49);

        // Simultaneous press and release of buttons 1 and 3
        t5 = cyc;
        buttons_raw[1] = 1'b1;
        buttons_raw[3] = 1'b1;
        expect_ev(t5 + 18, 1, 1, 1);
        expect_ev(t5 + 18, 1, 3, 1);
        expect_ev(t5 + 18, 2, 1, 1);
        expect_ev(t5 + 18, 2, 3, 1);
        step(30);
        buttons_raw[1] = 1'b0;
        buttons_raw[3] = 1'b0;
        buttons_raw[4] = 1'b0;
        expect_ev(t5 + 48, 1, 1, 0);
        expect_ev(t5 + 48, 1, 3, 0);
        expect_ev(t5 + 48, 1, 4, 0);
        expect_ev(t5 + 48, 3, 1, 1);
        expect_ev(t5 + 48, 3, 3, 1);
        expect_ev(t5 + 48, 3, 4, 1);
        step(30);

        // Reset mid-debounce of button 2
        t6 = cyc;
        buttons_raw[2] = 1'b1;
        step(8);
        reset_n = 1'b0;
        expect_ev(t6 + 8, 0, 0, 0);
        expect_ev(t6 + 8, 0, 2, 0);
        expect_ev(t6 + 8, 1, 0, 0);
        expect_ev(t6 + 8, 5, 0, 0);
        #1;
        chk_zero("mid_debounce");
        step(3);
        reset_n = 1'b1;
        expect_ev(t6 + 29, 0, 0, 1);
        expect_ev(t6 + 29, 0, 2, 1);
        expect_ev(t6 + 29, 1, 0, 1);
        expect_ev(t6 + 29, 1, 2, 1);
        expect_ev(t6 + 29, 2, 0, 1);
        expect_ev(t6 + 29, 2, 2, 1);
        step(34);

        // Reset mid-stretch
        reset_n = 1'b0;
        expect_ev(t6 + 45, 0, 0, 0);
        expect_ev(t6 + 45, 0, 2, 0);
        expect_ev(t6 + 45, 1, 0, 0);
        expect_ev(t6 + 45, 1, 2, 0);
        #1;
        chk_zero("mid_stretch");
        step(2);
        reset_n = 1'b1;
        expect_ev(t6 + 65, 0, 0, 1);
        expect_ev(t6 + 65, 0, 2, 1);
        expect_ev(t6 + 65, 1, 0, 1);
        expect_ev(t6 + 65, 1, 2, 1);
        expect_ev(t6 + 65, 2, 0, 1);
        expect_ev(t6 + 65, 2, 2, 1);
        expect_ev(t6 + 97, 5, 0, 1);
`ifdef BIC_LONG_PRESS_EN
        expect_ev(t6 + 165, 4, 0, 1);
        expect_ev(t6 + 165, 4, 2, 1);
`endif
        step(210);

        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL missing events: %0d left, first %s[%0d]=%0d at cycle %0d",
                     expq.size(), kn[expq[0].kind], expq[0].idx, expq[0].val, expq[0].cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
